// File: rtl/mult_control_unit.sv
// Purpose : sequencer for a 4x4 shift-add multiplier built from three 74194 registers.
// Latency : Start sampled at edge E0 -> Done high in the cycle after E10 (CLEAR, LOAD, 4x ADD/SHIFT, DONE).
// Backpr. : none; Start is sampled only in IDLE and ignored (never queued) while an operation runs.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   Start      begin one multiply (sampled in IDLE only)
//   Shift1     S1 per register: [2] multiplier, [1] upper product, [0] lower product
//   Shift0     S0 per register, same mapping; {S1,S0}: 00 hold, 01 shift right, 11 load
//   DataReset  active-low datapath clear, registered, also low while reset is low
//   Busy       operation in progress
//   Done       product valid
//
// Optional feature: define MULT_CTRL_DONE_HOLD_EN to hold DONE (Done=1, Busy=0)
// until Start is seen low; otherwise Done is a single-cycle pulse.
module mult_control_unit (
  input  logic       clock,
  input  logic       reset,
  input  logic       Start,
  output logic [2:0] Shift1,
  output logic [2:0] Shift0,
  output logic       DataReset,
  output logic       Busy,
  output logic       Done
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_ADD   = 3'd3;
  localparam logic [2:0] ST_SHIFT = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0] state_q, state_d;
  logic [1:0] count_q, count_d;
  logic       data_reset_q, data_reset_d;

  // Next-state and iteration counter.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        count_d = 2'd0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_ADD;
      end
      ST_ADD: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Count wraps back to 0 on the fourth shift, ready for the next run.
        count_d = count_q + 2'd1;
        state_d = (count_q == 2'd3) ? ST_DONE : ST_ADD;
      end
      ST_DONE: begin
`ifdef MULT_CTRL_DONE_HOLD_EN
        // Leaving only on Start low forces a low-then-high edge for the next run.
        if (!Start) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Registered from next-state so the clear pin sees a clean flop output
    // that is low for exactly the CLEAR cycle.
    data_reset_d = (state_d != ST_CLEAR);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      count_q      <= 2'd0;
      data_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      data_reset_q <= data_reset_d;
    end
  end

  // Gating with reset keeps the datapath cleared for the whole reset interval.
  assign DataReset = data_reset_q & reset;

  // Moore output decode.
  always_comb begin
    Shift1 = 3'b000;
    Shift0 = 3'b000;
    Busy   = 1'b1;
    Done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        Busy = 1'b0;
      end
      ST_LOAD: begin
        Shift1 = 3'b100;
        Shift0 = 3'b100;
      end
      ST_ADD: begin
        Shift1 = 3'b010;
        Shift0 = 3'b010;
      end
      ST_SHIFT: begin
        Shift1 = 3'b000;
        Shift0 = 3'b111;
      end
      ST_DONE: begin
        Done = 1'b1;
`ifdef MULT_CTRL_DONE_HOLD_EN
        Busy = 1'b0;
`endif
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mult_control_unit.sv
`timescale 1ns/1ps
module tb_mult_control_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       Start;
  logic [2:0] Shift1, Shift0;
  logic       DataReset, Busy, Done;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mult_control_unit dut (
    .clock    (clock),
    .reset    (reset),
    .Start    (Start),
    .Shift1   (Shift1),
    .Shift0   (Shift0),
    .DataReset(DataReset),
    .Busy     (Busy),
    .Done     (Done)
  );

  // 4-bit serial datapath: three 74194-style registers plus a carry bit.
  logic [3:0] mcand, mplier;
  logic [3:0] m_reg, up_reg, lo_reg;
  logic       carry;
  logic [4:0] sum;
  logic [7:0] product;

  assign sum     = {1'b0, up_reg} + (m_reg[0] ? {1'b0, mcand} : 5'd0);
  assign product = {up_reg, lo_reg};

  always_ff @(posedge clock or negedge DataReset) begin
    if (!DataReset) begin
      m_reg  <= 4'd0;
      up_reg <= 4'd0;
      lo_reg <= 4'd0;
      carry  <= 1'b0;
    end else begin
      case ({Shift1[2], Shift0[2]})
        2'b11:   m_reg <= mplier;
        2'b01:   m_reg <= {1'b0, m_reg[3:1]};
        default: ;
      endcase
      case ({Shift1[1], Shift0[1]})
        2'b11: begin
          up_reg <= sum[3:0];
          carry  <= sum[4];
        end
        2'b01:   up_reg <= {carry, up_reg[3:1]};
        default: ;
      endcase
      case ({Shift1[0], Shift0[0]})
        2'b11:   lo_reg <= 4'd0;
        2'b01:   lo_reg <= {up_reg[0], lo_reg[3:1]};
        default: ;
      endcase
    end
  end

  wire [8:0] outs = {Shift1, Shift0, DataReset, Busy, Done};

`ifdef MULT_CTRL_DONE_HOLD_EN
  localparam logic DONE_BUSY = 1'b0;
  localparam bit   HOLD      = 1'b1;
`else
  localparam logic DONE_BUSY = 1'b1;
  localparam bit   HOLD      = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       start;
    logic [8:0] exp;
  } row_t;

  function automatic row_t mk(input logic st, input logic [2:0] s1, input logic [2:0] s0,
                              input logic dr, input logic bz, input logic dn);
    row_t r;
    r.start = st;
    r.exp   = {s1, s0, dr, bz, dn};
    return r;
  endfunction

  // One multiply: pulse Start, watch ncyc cycles, compare latency, Done count,
  // datapath clear at LOAD and the final product against the expected value.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp_prod,
                        input int repulse, input int ncyc, input string tag);
    int done_cnt;
    int first;
    done_cnt = 0;
    first    = -1;
    mcand  = a;
    mplier = b;
    Start  = 1'b1;
    @(negedge clock);
    for (int n = 1; n <= ncyc; n++) begin
      Start = (n == repulse);
      if (n == 2) chk({tag, " clear_at_load"}, product, 0);
      if (Done) begin
        done_cnt++;
        if (first < 0) first = n;
      end
      @(negedge clock);
    end
    Start = 1'b0;
    chk({tag, " done_latency"}, first, 11);
    chk({tag, " done_count"}, done_cnt, 1);
    chk({tag, " product"}, product, exp_prod);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  row_t tbl[13];
  vec_t vecs[4];
  logic dn_hist[40];
  logic bz_hist[40];

  initial begin
    // Expected cycle-by-cycle trace of one FxF operation.
    tbl[0]  = mk(1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);   // IDLE, Start sampled at E0
    tbl[1]  = mk(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);   // CLEAR
    tbl[2]  = mk(1'b0, 3'b100, 3'b100, 1'b1, 1'b1, 1'b0);   // LOAD
    for (int i = 3; i <= 10; i++) begin
      if (i % 2 == 1) tbl[i] = mk(1'b0, 3'b010, 3'b010, 1'b1, 1'b1, 1'b0); // ADD
      else            tbl[i] = mk(1'b0, 3'b000, 3'b111, 1'b1, 1'b1, 1'b0); // SHIFT
    end
    tbl[11] = mk(1'b0, 3'b000, 3'b000, 1'b1, DONE_BUSY, 1'b1); // DONE
    tbl[12] = mk(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);      // IDLE

    vecs[0] = '{a: 4'h5, b: 4'h3, p: 8'h0F};
    vecs[1] = '{a: 4'h0, b: 4'h9, p: 8'h00};
    vecs[2] = '{a: 4'h9, b: 4'h0, p: 8'h00};
    vecs[3] = '{a: 4'h8, b: 4'h8, p: 8'h40};

    // Reset state.
    reset  = 1'b0;
    Start  = 1'b0;
    mcand  = 4'd0;
    mplier = 4'd0;
    @(negedge clock);
    @(negedge clock);
    chk("reset_outputs", outs, 9'h000);
    reset = 1'b1;
    @(negedge clock);
    chk("after_release", outs, 9'h004);

    // Table-driven trace of FxF.
    mcand  = 4'hF;
    mplier = 4'hF;
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("trace_row%0d", i), outs, tbl[i].exp);
      if (i == 11) chk("trace_product", product, 8'hE1);
      Start = tbl[i].start;
      @(negedge clock);
    end

    // Directed operand vectors.
    foreach (vecs[k]) run_op(vecs[k].a, vecs[k].b, vecs[k].p, 0, 30, $sformatf("vec%0d", k));

    // Start re-pulsed mid-operation is ignored.
    run_op(4'hD, 4'hB, 8'h8F, 4, 30, "repulse");

    // Reset during the third SHIFT aborts the operation.
    mcand  = 4'h5;
    mplier = 4'h5;
    Start  = 1'b1;
    @(negedge clock);
    Start = 1'b0;
    repeat (7) @(negedge clock);
    chk("abort_in_shift3", outs, 9'b000_111_1_1_0);
    reset = 1'b0;
    #1;
    chk("abort_async_outputs", outs, 9'h000);
    @(negedge clock);
    reset = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        @(negedge clock);
        if (Done) seen++;
      end
      chk("abort_no_done", seen, 0);
      chk("abort_idle_busy", Busy, 0);
    end
    run_op(4'h7, 4'h6, 8'h2A, 0, 30, "post_abort");

    // Back-to-back: second op starts right as IDLE is re-entered.
    run_op(4'hA, 4'hC, 8'h78, 0, 11, "b2b_first");
    run_op(4'h1, 4'h1, 8'h01, 0, 30, "b2b_second");

    // Start held high for 20 cycles.
    mcand  = 4'h3;
    mplier = 4'h2;
    for (int n = 0; n < 40; n++) begin
      dn_hist[n] = Done;
      bz_hist[n] = Busy;
      Start = (n < 20);
      @(negedge clock);
    end
    Start = 1'b0;
    begin
      int rises, high, r0, r1;
      rises = 0; high = 0; r0 = -1; r1 = -1;
      for (int n = 0; n < 40; n++) begin
        if (dn_hist[n]) high++;
        if (dn_hist[n] && (n == 0 || !dn_hist[n-1])) begin
          rises++;
          if (r0 < 0) r0 = n;
          else if (r1 < 0) r1 = n;
        end
      end
      chk("held_first_done", r0, 11);
      if (HOLD) begin
        chk("held_rises", rises, 1);
        chk("held_done_cycles", high, 10);
        chk("held_busy_in_done", bz_hist[15], 0);
        chk("held_idle_after", bz_hist[30], 0);
      end else begin
        chk("held_rises", rises, 2);
        chk("held_period", r1 - r0, 12);
        chk("held_done_cycles", high, 2);
      end
      chk("held_product", product, 8'h06);
    end
    @(negedge clock);

    // Randomised operations against plain multiplication.
    for (int t = 0; t < 20; t++) begin
      logic [3:0] ra, rb;
      logic [7:0] rp;
      int rep;
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rep = $urandom_range(0, 10);
      rp  = 8'(int'(ra) * int'(rb));
      run_op(ra, rb, rp, rep, 30, $sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_control_unit.md
MULT_CONTROL_UNIT -- requirements
Module: mult_control_unit

Interface
REQ-001 clock  input  1  rising-edge system clock; the only clock.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 Start  input  1  request to begin one 4x4 multiply; sampled only in IDLE.
REQ-004 Shift1  output  3  S1 controls for the 74194 registers: bit2 multiplier, bit1 upper product, bit0 lower product.
REQ-005 Shift0  output  3  S0 controls, same bit mapping as Shift1; per-bit code {S1,S0}: 00 hold, 01 shift right, 11 parallel load.
REQ-006 DataReset  output  1  active-low clear to the datapath reset pin.
REQ-007 Busy  output  1  high in every state except IDLE, and DONE under REQ-024.
REQ-008 Done  output  1  product valid indication.

Function
REQ-009 FSM states SHALL be IDLE, CLEAR, LOAD, ADD, SHIFT, DONE, plus a 2-bit iteration counter Count.
REQ-010 IDLE: Shift1/Shift0 = 000/000; Start=1 at a rising edge -> CLEAR; else stay.
REQ-011 CLEAR: DataReset low for exactly this one cycle, shifts 000/000, Count<=0; -> LOAD.
REQ-012 LOAD: multiplier code 11, upper/lower 00 (Shift1=100, Shift0=100); -> ADD.
REQ-013 ADD: upper code 11 (load Sum), others 00 (Shift1=010, Shift0=010); -> SHIFT.
REQ-014 SHIFT: all three registers code 01 (Shift1=000, Shift0=111); Count<=Count+1; Count==3 -> DONE, else -> ADD.
REQ-015 DONE: shifts 000/000, Done=1; -> IDLE (see REQ-024).
REQ-016 Exactly four ADD/SHIFT pairs per operation; no early termination for zero operands.
REQ-017 Latency: Start sampled at edge E0 -> Done=1 in the cycle after E10; product final at E10.
REQ-018 Start while not in IDLE SHALL be ignored, with no queuing; Start held high continuously SHALL start a new operation each time IDLE is re-entered.
REQ-019 DataReset SHALL come directly from a flop (glitch-free), ANDed with reset so the datapath also clears while reset is low.
REQ-020 Shift1/Shift0/Busy/Done SHALL be Moore outputs decoded from state only.
REQ-021 Operand rule: Multiplier stable during LOAD; Multiplicant stable from LOAD through the last ADD.

Reset
REQ-022 reset low SHALL force, asynchronously: state IDLE, Count 0, Shift1=Shift0=000, Busy=0, Done=0, DataReset=0 (while low), DataReset flop=1.
REQ-023 reset low mid-operation SHALL abort the operation; after release, the FSM waits in IDLE for a new Start, and no Done pulse is issued for the aborted operation.

Configuration
REQ-024 Macro MULT_CTRL_DONE_HOLD_EN defined: DONE holds (Done=1, Busy=0) until Start=0 at an edge, then -> IDLE; a new start requires Start low then high.
REQ-025 Macro MULT_CTRL_DONE_HOLD_EN undefined: Done is a single-cycle pulse, and DONE -> IDLE unconditionally.

Verification (bench = this block + 4-bit serial datapath)
REQ-026 Multiplicant=F, Multiplier=F, one-cycle Start -> Done pulse 11 cycles after the Start edge; Product=8'hE1; the Shift sequence follows REQ-011..015.
REQ-027 5 x 3 -> Product=8'h0F; 0 x 9 -> 8'h00; 9 x 0 -> 8'h00; 8 x 8 -> 8'h40.
REQ-028 Start re-pulsed at cycle 4 of an operation -> ignored; exactly one Done; Product of the first operands.
REQ-029 reset low for one cycle during the third SHIFT -> all outputs at reset values immediately; no Done; next Start with 7 x 6 -> 8'h2A.
REQ-030 Two back-to-back operations, with the second operation's DataReset pulse verified to clear the previous product: A x C -> 8'h78, then 1 x 1 -> 8'h01.
REQ-031 MULT_CTRL_DONE_HOLD_EN defined, Start held high 20 cycles -> Done stays high after completion until Start falls, with no restart; without the macro, the same stimulus -> repeated operations each 12 cycles apart.
